// File: rtl/ysyx_22040125_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the canonical NOP and the default reset fetch address.
package ysyx_22040125_ifu_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22040125_if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds under stall,
// drops to a bubble on flush or when nothing new arrives.
// Build option: IFU_MISALIGN_CHECK_EN adds the misaligned-target flag.
module ysyx_22040125_if_id_reg
    import ysyx_22040125_ifu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [ILEN-1:0] i_inst,
`ifdef IFU_MISALIGN_CHECK_EN
    input  logic            i_mis,
    output logic            o_mis,
`endif
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [ILEN-1:0] o_inst
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_pc    <= '0;
            o_inst  <= ILEN'(NOP_INST);
`ifdef IFU_MISALIGN_CHECK_EN
            o_mis   <= 1'b0;
`endif
        end else if (i_flush) begin
            o_valid <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            o_mis   <= 1'b0;
`endif
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_pc    <= i_pc;
            o_inst  <= i_inst;
`ifdef IFU_MISALIGN_CHECK_EN
            o_mis   <= i_mis;
`endif
        end else if (!i_stall) begin
            o_valid <= 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            o_mis   <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/ysyx_22040125_ifu.sv
// Instruction fetch unit: PC, single-outstanding fetch FSM, one-entry hold
// buffer and IF/ID register. Build option: IFU_MISALIGN_CHECK_EN.
module ysyx_22040125_ifu
    import ysyx_22040125_ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_control,
    input  logic            IF_Flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_inst
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic            id_misalign
`endif
);

    ifu_state_e      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    logic            r_req_valid;
    logic            r_drop;
    logic [ILEN-1:0] r_hold_inst;
    logic            r_mis;
    logic            r_mis_sent;

    logic            w_flush;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_redir_mis;
    logic            w_hs;
    logic            w_rsp_take;
    logic            w_hold_take;
    logic            w_mis_take;
    logic            w_adv;
    logic            w_enter;
    logic            w_mis_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [ILEN-1:0] w_id_inst;
    logic            w_id_load;

    assign w_flush = ~IF_Flush;

`ifdef IFU_MISALIGN_CHECK_EN
    assign w_redir_pc  = redirect_pc;
    assign w_redir_mis = |redirect_pc[1:0];
`else
    assign w_redir_pc  = redirect_pc & ~XLEN'(3);
    assign w_redir_mis = 1'b0;
`endif

    assign w_hs        = r_req_valid & imem_req_ready;
    assign w_rsp_take  = (r_state == S_WAIT) & imem_rsp_valid & ~w_flush & ~r_drop & ~stall_control;
    assign w_hold_take = (r_state == S_HOLD) & ~r_mis & ~w_flush & ~stall_control;
    assign w_mis_take  = (r_state == S_HOLD) & r_mis & ~r_mis_sent & ~w_flush & ~stall_control;
    assign w_adv       = w_rsp_take | w_hold_take;
    assign w_id_load   = w_adv | w_mis_take;

    // Every path that finishes with the current fetch and starts the next one.
    assign w_enter = (r_state == S_RESET)
                   | ((r_state == S_WAIT) & imem_rsp_valid & (w_flush | r_drop | ~stall_control))
                   | ((r_state == S_HOLD) & (w_flush | w_hold_take));

    assign w_mis_nxt = w_flush ? w_redir_mis : r_mis;

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_flush) begin
            w_pc_nxt = w_redir_pc;
        end else if (w_adv) begin
            w_pc_nxt = r_pc + XLEN'(4);
        end
    end

    always_comb begin
        w_id_inst = imem_rsp_data;
        if (w_mis_take) begin
            w_id_inst = ILEN'(NOP_INST);
        end else if (r_state == S_HOLD) begin
            w_id_inst = r_hold_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RESET;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_req_valid <= 1'b0;
            r_drop      <= 1'b0;
            r_hold_inst <= ILEN'(NOP_INST);
            r_mis       <= 1'b0;
            r_mis_sent  <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;

            if (w_flush) begin
                r_mis      <= w_redir_mis;
                r_mis_sent <= 1'b0;
            end else if (w_mis_take) begin
                r_mis_sent <= 1'b1;
            end

            case (r_state)
                S_REQ: begin
                    // The outstanding request is never withdrawn; a flush only marks its reply stale.
                    if (w_hs) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                    if (w_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_drop <= 1'b0;
                        if (!w_flush && !r_drop && stall_control) begin
                            r_hold_inst <= imem_rsp_data;
                            r_state     <= S_HOLD;
                        end
                    end else if (w_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_enter) begin
                if (w_mis_nxt) begin
                    r_state     <= S_HOLD;
                    r_req_valid <= 1'b0;
                end else begin
                    r_state     <= S_REQ;
                    r_req_valid <= 1'b1;
                    r_req_addr  <= w_pc_nxt;
                end
            end
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;

    ysyx_22040125_if_id_reg #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_id_load),
        .i_stall (stall_control),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_inst  (w_id_inst),
`ifdef IFU_MISALIGN_CHECK_EN
        .i_mis   (w_mis_take),
        .o_mis   (id_misalign),
`endif
        .o_valid (id_valid),
        .o_pc    (id_pc),
        .o_inst  (id_inst)
    );

endmodule

// File: tb/tb_ysyx_22040125_ifu.sv
// Bench for the fetch unit: directed cycle table, asynchronous reset check,
// then randomized traffic against an instruction-stream reference model.
module tb_ysyx_22040125_ifu;

    localparam logic [63:0] A   = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_control;
    logic        IF_Flush;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_inst;

    int errors = 0;
    int checks = 0;

    // Reference model state: memory responder and expected instruction stream.
    logic        m_pend;
    int          m_cnt;
    logic [63:0] m_addr;
    logic [63:0] exp_pc;
    int          delivered;

    always #5 clk = ~clk;

    ysyx_22040125_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_control  (stall_control),
        .IF_Flush       (IF_Flush),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
    );

    typedef struct {
        logic        stall;
        logic        flush_n;
        logic [63:0] redir;
        logic        ready;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        e_reqv;
        logic [63:0] e_addr;
        logic        e_idv;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] dk(input int k);
        return 32'h1000_0013 + 32'(k) * 32'h100;
    endfunction

    function automatic vec_t mk(input logic st, input logic fn, input logic [63:0] rd,
                                input logic rdy, input logic rv, input logic [31:0] rdat,
                                input logic erv, input logic [63:0] ea, input logic eiv,
                                input logic [63:0] ep, input logic [31:0] ei);
        vec_t v;
        v.stall = st; v.flush_n = fn; v.redir = rd; v.ready = rdy;
        v.rsp_v = rv; v.rsp_d = rdat; v.e_reqv = erv; v.e_addr = ea;
        v.e_idv = eiv; v.e_pc = ep; v.e_inst = ei;
        return v;
    endfunction

    task automatic step_auto(input logic st, input logic fl_n, input logic [63:0] rd);
        logic        p_reqv, p_hs, p_rsp, p_idv;
        logic [63:0] p_addr, p_idpc;
        logic [31:0] p_inst;
        stall_control  = st;
        IF_Flush       = fl_n;
        redirect_pc    = rd;
        imem_req_ready = ($urandom_range(0, 3) != 0);
        p_reqv = imem_req_valid;
        p_addr = imem_req_addr;
        p_hs   = imem_req_valid && imem_req_ready;
        p_rsp  = imem_rsp_valid;
        p_idv  = id_valid;
        p_idpc = id_pc;
        p_inst = id_inst;
        @(posedge clk);
        #1;
        if (!fl_n) begin
            chk("flush_kills_id", 64'(id_valid), 64'd0);
            exp_pc = rd & ~64'h3;
        end else if (st) begin
            chk("stall_hold_valid", 64'(id_valid), 64'(p_idv));
            chk("stall_hold_pc", id_pc, p_idpc);
            chk("stall_hold_inst", 64'(id_inst), 64'(p_inst));
        end else if (id_valid) begin
            chk("stream_pc", id_pc, exp_pc);
            chk("stream_inst", 64'(id_inst), 64'(memf(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            delivered++;
        end
        if (p_reqv && !p_hs) begin
            chk("req_valid_stable", 64'(imem_req_valid), 64'd1);
            chk("req_addr_stable", imem_req_addr, p_addr);
        end
        if (p_rsp) m_pend = 1'b0;
        if (p_hs) begin
            chk("one_outstanding", 64'(m_pend), 64'd0);
            m_pend = 1'b1;
            m_addr = p_addr;
            m_cnt  = $urandom_range(0, 2);
        end else if (m_pend && m_cnt > 0) begin
            m_cnt--;
        end
        imem_rsp_valid = m_pend && (m_cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? memf(m_addr) : $urandom;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        int          n;

        tbl.push_back(mk(0,1,0,     1,0,0,     1,A,       0,0,NOP));
        tbl.push_back(mk(0,1,0,     1,0,0,     0,A,       0,0,NOP));
        tbl.push_back(mk(0,1,0,     0,1,dk(0), 1,A+4,     1,A,dk(0)));
        tbl.push_back(mk(0,1,0,     1,0,0,     0,A+4,     0,A,dk(0)));
        tbl.push_back(mk(0,1,0,     0,1,dk(1), 1,A+8,     1,A+4,dk(1)));
        tbl.push_back(mk(1,1,0,     1,0,0,     0,A+8,     1,A+4,dk(1)));
        tbl.push_back(mk(1,1,0,     0,1,dk(2), 0,A+8,     1,A+4,dk(1)));
        tbl.push_back(mk(1,1,0,     0,0,0,     0,A+8,     1,A+4,dk(1)));
        tbl.push_back(mk(1,1,0,     0,0,0,     0,A+8,     1,A+4,dk(1)));
        tbl.push_back(mk(0,1,0,     0,0,0,     1,A+12,    1,A+8,dk(2)));
        tbl.push_back(mk(0,1,0,     1,0,0,     0,A+12,    0,A+8,dk(2)));
        tbl.push_back(mk(0,0,A+256, 0,0,0,     0,A+12,    0,A+8,dk(2)));
        tbl.push_back(mk(0,1,0,     0,1,dk(3), 1,A+256,   0,A+8,dk(2)));
        tbl.push_back(mk(0,0,A+512, 0,0,0,     1,A+256,   0,A+8,dk(2)));
        tbl.push_back(mk(0,1,0,     0,0,0,     1,A+256,   0,A+8,dk(2)));
        tbl.push_back(mk(0,1,0,     1,0,0,     0,A+256,   0,A+8,dk(2)));
        tbl.push_back(mk(0,1,0,     0,1,dk(4), 1,A+512,   0,A+8,dk(2)));
        tbl.push_back(mk(0,1,0,     1,0,0,     0,A+512,   0,A+8,dk(2)));
        tbl.push_back(mk(1,0,A+768, 0,1,dk(5), 1,A+768,   0,A+8,dk(2)));
        tbl.push_back(mk(0,1,0,     1,0,0,     0,A+768,   0,A+8,dk(2)));
        tbl.push_back(mk(0,1,0,     0,1,dk(6), 1,A+772,   1,A+768,dk(6)));
        tbl.push_back(mk(1,0,A+1024,0,0,0,     1,A+772,   0,A+768,dk(6)));
        tbl.push_back(mk(0,1,0,     1,0,0,     0,A+772,   0,A+768,dk(6)));
        tbl.push_back(mk(0,1,0,     0,1,dk(7), 1,A+1024,  0,A+768,dk(6)));
        tbl.push_back(mk(0,1,0,     1,0,0,     0,A+1024,  0,A+768,dk(6)));
        tbl.push_back(mk(0,1,0,     0,1,dk(8), 1,A+1028,  1,A+1024,dk(8)));

        rst_n = 1'b0; stall_control = 1'b0; IF_Flush = 1'b1; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        m_pend = 1'b0; m_cnt = 0; m_addr = '0; exp_pc = A; delivered = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_valid", 64'(imem_req_valid), 64'd0);
        chk("reset_req_addr", imem_req_addr, A);
        chk("reset_id_valid", 64'(id_valid), 64'd0);
        chk("reset_id_pc", id_pc, 64'd0);
        chk("reset_id_inst", 64'(id_inst), 64'(NOP));
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            stall_control  = tbl[i].stall;
            IF_Flush       = tbl[i].flush_n;
            redirect_pc    = tbl[i].redir;
            imem_req_ready = tbl[i].ready;
            imem_rsp_valid = tbl[i].rsp_v;
            imem_rsp_data  = tbl[i].rsp_d;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_req_valid", i), 64'(imem_req_valid), 64'(tbl[i].e_reqv));
            chk($sformatf("row%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("row%0d_id_valid", i), 64'(id_valid), 64'(tbl[i].e_idv));
            chk($sformatf("row%0d_id_pc", i), id_pc, tbl[i].e_pc);
            chk($sformatf("row%0d_id_inst", i), 64'(id_inst), 64'(tbl[i].e_inst));
        end

        // Move into S_WAIT, then pulse reset mid-cycle.
        stall_control = 1'b0; IF_Flush = 1'b1; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_wait", 64'(imem_req_valid), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("async_rst_req_addr", imem_req_addr, A);
        chk("async_rst_id_valid", 64'(id_valid), 64'd0);
        chk("async_rst_id_pc", id_pc, 64'd0);
        chk("async_rst_id_inst", 64'(id_inst), 64'(NOP));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pend = 1'b0; exp_pc = A;
        imem_rsp_valid = 1'b0;

        n = 0;
        while (!imem_req_valid && n < 10) begin
            step_auto(1'b0, 1'b1, 64'd0);
            n++;
        end
        chk("restart_req_seen", 64'(imem_req_valid), 64'd1);
        chk("restart_req_addr", imem_req_addr, A);

        for (int c = 0; c < 2000; c++) begin
            logic st, fl_n;
            st   = ($urandom_range(0, 3) == 0);
            fl_n = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) == 0)
                rd = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            else
                rd = A + 64'($urandom_range(0, 16383));
            step_auto(st, fl_n, rd);
        end
        chk("stream_progress", 64'(delivered >= 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040125_ifu.md
Name: ysyx_22040125_ifu

Overview:
- Instruction fetch unit: PC register, single-outstanding fetch FSM toward instruction memory, one-entry response hold buffer, and the IF/ID pipeline register.
- Sits directly upstream of the decode stage and the hazard unit.
- Consumes the hazard unit's stall_control and IF_Flush (active-low flush) plus the branch/jump redirect target.
- Produces id_valid / id_pc / id_inst for decode.

Parameters:
- XLEN, 64, PC / address width.
- ILEN, 32, instruction width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall_control  input  1  1 = hold IF/ID register and PC (load-use hazard).
- IF_Flush  input  1  active-low; 0 = redirect/flush this cycle.
- redirect_pc  input  XLEN  new fetch PC, sampled when IF_Flush==0.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  fetch address, registered.
- imem_rsp_valid  input  1  response data valid (exactly one per accepted request, at least 1 cycle later).
- imem_rsp_data  input  ILEN  fetched instruction.
- id_valid  output  1  IF/ID slot holds a valid instruction.
- id_pc  output  XLEN  PC of id_inst.
- id_inst  output  ILEN  instruction to decode.

Behaviour:
- Reset values:
  - state=S_RESET, pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC.
  - drop=0, id_valid=0, id_pc=0, id_inst=32'h0000_0013 (NOP).
- States:
  - S_RESET: one cycle after rst_n release -> S_REQ.
  - S_REQ: imem_req_valid=1, imem_req_addr=pc. On handshake (valid & ready) -> S_WAIT.
  - S_WAIT: on imem_rsp_valid:
    - drop=1: discard the response, clear drop, -> S_REQ, no pc change.
    - otherwise, if ID accepts (stall_control==0): load IF/ID, pc<=pc+4, -> S_REQ.
    - otherwise, capture into hold buffer (data + pc) -> S_HOLD.
  - S_HOLD: no request. When stall_control==0: load IF/ID from buffer, pc<=pc+4, -> S_REQ.
- Request rule: once imem_req_valid is high, it and imem_req_addr stay stable until the handshake, including across a flush.
- IF/ID register:
  - Loads only on the transitions above; holds all fields while stall_control==1.
  - If stall_control==0 and no instruction is ready, id_valid<=0 (bubble).
- Flush (IF_Flush==0):
  - pc<=redirect_pc and id_valid<=0 in the same edge.
  - S_REQ without handshake: set drop; stay in S_REQ holding the old address; the old response is discarded.
  - S_REQ with handshake that cycle: set drop, -> S_WAIT.
  - S_WAIT with no response this cycle: set drop.
  - S_WAIT with response this cycle: discard it, -> S_REQ.
  - S_HOLD: discard buffer, -> S_REQ.
  - Flush has priority over stall_control. Flush in S_RESET only updates pc.
- pc+4 wraps modulo 2^XLEN.
- Throughput: at most one instruction per 2 cycles. Latency with a zero-wait memory: request at cycle N, response at N+1, id_valid visible at N+2.
- rst_n asserted mid-operation: immediate return to reset values. Any in-flight memory response after reset release is ignored until the first new request is accepted; the memory guarantees the response is cancelled on reset.

Optional Feature:
- Macro IFU_MISALIGN_CHECK_EN.
- Defined:
  - Adds output id_misalign (1 bit, reset 0).
  - A redirect_pc with bits[1:0]!=0 issues no memory request. The next accepted ID slot gets id_valid=1, id_misalign=1, id_pc=redirect_pc, id_inst=NOP.
  - The FSM then waits in S_HOLD-equivalent until a new flush arrives.
- Undefined: redirect_pc[1:0] is forced to 2'b00 and no extra port exists.

Decomposition:
- Package ysyx_22040125_ifu_pkg:
  - State encoding (S_RESET, S_REQ, S_WAIT, S_HOLD).
  - NOP constant 32'h0000_0013.
  - Default RESET_PC.
- One natural sub-module, ysyx_22040125_if_id_reg:
  - IF/ID register with load / stall / flush inputs and reset to bubble.
  - The FSM and PC stay in the top module.

Test Plan:
- Reset release, ready=1, 1-cycle response latency:
  - First request addr 0x8000_0000 two cycles after release.
  - Following addresses 0x8000_0004, 0x8000_0008.
  - id_valid every other cycle with matching id_pc.
- Response arrives while stall_control=1 for 3 cycles:
  - Instruction held in S_HOLD; id outputs unchanged.
  - On stall release, id_inst equals the held data; no duplicate or lost instruction.
- IF_Flush=0 with redirect_pc=0x8000_0100 while in S_WAIT:
  - Pending response discarded; id_valid=0 next cycle.
  - Next request addr 0x8000_0100.
- Flush in S_REQ with imem_req_ready=0 for 2 cycles:
  - imem_req_addr stays at the old value until ready.
  - Its response is dropped; the following request uses the redirect target.
- Simultaneous IF_Flush=0 and stall_control=1: flush wins, id_valid=0, pc=redirect_pc.
- rst_n pulsed low while in S_WAIT: all outputs return to reset values asynchronously; fetch restarts at RESET_PC.
